instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage that reads the 16-entry program ROM. It drives the ROM address, latches the returned word into an instruction register, and presents it to decode/execute over a valid/ready handshake. It predecodes unconditional jmp (opcode 4'b1000) for zero-bubble redirect. It accepts a redirect from execute for taken br (opcode 4'b1100) or any other flush.

Parameters:
ADDR_W, 4, program address width (ROM depth 2^ADDR_W)
INST_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset
OPC_JMP, 4'b1000, opcode predecoded as unconditional jump

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rom_addr  out  ADDR_W  ROM address; combinational copy of pc
rom_inst  in  INST_W  ROM data; combinational, valid in the same cycle as rom_addr
ir  out  INST_W  latched instruction presented to decode
ir_pc  out  ADDR_W  address ir was fetched from
ir_valid  out  1  ir holds an undelivered instruction
ir_ready  in  1  decode accepts ir this cycle when ir_valid=1
redirect  in  1  execute flush request, one-cycle pulse
redirect_target  in  ADDR_W  new PC when redirect=1
halt  in  1  level; blocks new fetches while high
pc  out  ADDR_W  current fetch PC (debug/LED)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, state=IDLE. Reset overrides redirect, halt and ir_ready.
- States: IDLE, RUN, HALTED.
- IDLE: one bubble cycle after reset. Next state is RUN, or HALTED if halt=1. No fetch occurs.
- RUN: fetch_en = (!ir_valid || ir_ready) && !halt.
  - On fetch_en: ir<=rom_inst, ir_pc<=pc, ir_valid<=1.
  - pc<=rom_inst[11:8] if rom_inst[15:12]==OPC_JMP, else pc+1.
- Delivery without refill: ir_valid && ir_ready && halt sets ir_valid<=0, pc held, state<=HALTED.
- Stall: ir_valid && !ir_ready holds ir, ir_pc, pc and ir_valid unchanged.
- HALTED: no fetch; ir drains via handshake. halt=0 returns to RUN (next fetch the following cycle).
- Redirect: highest priority after rst, in any state. pc<=redirect_target, ir_valid<=0 (flushes held ir even if ir_ready=1), state<=RUN if halt=0, else HALTED. The first instruction from the target is valid one cycle later.
- jmp is still delivered in ir. Execute treats it as a no-op and must not redirect on it. br is not predecoded; execute resolves it and pulses redirect.
- PC arithmetic is modulo 2^ADDR_W: pc=15 wraps to 0.
- Throughput: 1 instruction/cycle with ir_ready held high, including across jmp.
- rom_addr==pc at all times; it is not registered separately.

Decomposition:
- Shared package isa_pkg holds opcode constants (OPC_LOAD=4'b0001, OPC_ADD=4'b0010, OPC_SUB=4'b0011, OPC_JMP=4'b1000, OPC_SUBI=4'b1011, OPC_BR=4'b1100, OPC_MOV=4'b1110, OPC_OUT=4'b1111) and field positions: opcode [15:12], target/rd [11:8].
- The state encoding is local to this block.
- One natural sub-module, pc_next, is combinational: it selects redirect_target, the jmp target or pc+1.

Test Plan:
- Reset release, ir_ready=1, ROM {0:16'h1E07, 1:16'hBE01, 2:16'hCA00, 3:16'hFE00, 4:16'h8100}:
  - ir_valid first high at the 2nd edge after rst low, with ir=16'h1E07, ir_pc=0.
  - ir_pc sequence is then 1,2,3,4,1,2,… with no gaps (jmp at 4 gives zero bubble).
- ir_ready=0 for 3 cycles while ir_pc=2:
  - ir stays 16'hCA00, pc and rom_addr stay 3.
  - After ir_ready=1, the next ir_pc=3 with ir=16'hFE00.
- Redirect pulse with target 10 while ir_valid=1, ir_pc=3, ROM {10:16'hF200, 11:16'h8A00}:
  - The next cycle has ir_valid=0.
  - Then ir_pc=10,11,10,11…
- Redirect during stall (ir_ready=0) plus ir_ready=1 in the same cycle: held ir is dropped (not counted as delivered) and pc=target.
- Redirect to 15 with ROM[15]=16'h0000: ir_pc=15 then 0 (wrap).
- halt=1 mid-run with ir_ready=1:
  - The current ir is delivered, then ir_valid=0 and pc frozen.
  - halt=0 resumes at the frozen pc.
- Also: rst asserted mid-stall gives ir_valid=0, pc=0 at the next edge; a concurrent redirect is ignored.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch stage and its consumers.
// Holds widths, opcode constants, instruction field positions and a jmp predecode helper.
package isa_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned INST_W = 16;
    localparam int unsigned OPC_W  = 4;

    // Instruction field positions
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned TGT_MSB = 11;
    localparam int unsigned TGT_LSB = 8;

    localparam logic [OPC_W-1:0] OPC_LOAD = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'b0011;
    localparam logic [OPC_W-1:0] OPC_JMP  = 4'b1000;
    localparam logic [OPC_W-1:0] OPC_SUBI = 4'b1011;
    localparam logic [OPC_W-1:0] OPC_BR   = 4'b1100;
    localparam logic [OPC_W-1:0] OPC_MOV  = 4'b1110;
    localparam logic [OPC_W-1:0] OPC_OUT  = 4'b1111;

    // Decoded view of one instruction word
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [3:0]       rd;
        logic [7:0]       imm;
    } inst_t;

    function automatic logic is_opc(input logic [OPC_W-1:0] opcode,
                                    input logic [OPC_W-1:0] match);
        return opcode == match;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// ROM and decode-handshake bundle between the fetch stage and its neighbours.
//   rom_addr  fetch -> ROM     address (combinational copy of pc)
//   rom_inst  ROM   -> fetch   instruction word for rom_addr
//   ir        fetch -> decode  latched instruction
//   ir_pc     fetch -> decode  address ir came from
//   ir_valid  fetch -> decode  ir holds an undelivered instruction
//   ir_ready  decode -> fetch  decode accepts ir this cycle
interface instruction_fetch_if
    import isa_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned IW = INST_W
);
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_inst;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;

    modport master (
        output rom_addr, ir, ir_pc, ir_valid,
        input  rom_inst, ir_ready
    );

    modport slave (
        input  rom_addr, ir, ir_pc, ir_valid,
        output rom_inst, ir_ready
    );
endinterface

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC selection: redirect target, predecoded jmp target, or sequential pc+1.
//   redirect/redirect_target  flush request from execute
//   pc                        current fetch PC
//   opcode/jmp_target         fields of the word being fetched
//   next_pc                   selected PC (mod 2^ADDR_W)
module pc_next
    import isa_pkg::*;
#(
    parameter int unsigned      ADDR_W  = isa_pkg::ADDR_W,
    parameter logic [OPC_W-1:0] OPC_JMP = isa_pkg::OPC_JMP
) (
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic [ADDR_W-1:0] pc,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (redirect) begin
            next_pc = redirect_target;
        end else if (is_opc(opcode, OPC_JMP)) begin
            next_pc = jmp_target;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the ROM address, latches the word into ir and offers it to
// decode over valid/ready. Unconditional jmp is predecoded for zero-bubble redirect;
// execute may flush via redirect. halt blocks new fetches.
//   clk, rst                      clock, synchronous active-high reset
//   bus (master)                  ROM address/data and ir handshake
//   redirect, redirect_target     flush request and new PC
//   halt                          level, blocks new fetches
//   pc                            current fetch PC
module instruction_fetch
    import isa_pkg::*;
#(
    parameter int unsigned      ADDR_W   = isa_pkg::ADDR_W,
    parameter int unsigned      INST_W   = isa_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OPC_W-1:0] OPC_JMP  = isa_pkg::OPC_JMP
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_target,
    input  logic                halt,
    output logic [ADDR_W-1:0]   pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic [INST_W-1:0] ir_q;
    logic [ADDR_W-1:0] ir_pc_q;
    logic              ir_valid_q;
    logic [ADDR_W-1:0] next_pc;
    logic              fetch_en;
    logic              deliver;

    assign bus.rom_addr = pc;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;

    assign deliver  = ir_valid_q && bus.ir_ready;
    assign fetch_en = (state == RUN) && (!ir_valid_q || bus.ir_ready) && !halt;

    pc_next #(
        .ADDR_W (ADDR_W),
        .OPC_JMP(OPC_JMP)
    ) u_pc_next (
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .pc             (pc),
        .opcode         (bus.rom_inst[OPC_MSB:OPC_LSB]),
        .jmp_target     (ADDR_W'(bus.rom_inst[TGT_MSB:TGT_LSB])),
        .next_pc        (next_pc)
    );

    // Fetch control and pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            state      <= IDLE;
        end else if (redirect) begin
            // Flush wins over any handshake in flight; held ir is dropped
            pc         <= next_pc;
            ir_valid_q <= 1'b0;
            state      <= halt ? HALTED : RUN;
        end else begin
            case (state)
                IDLE: begin
                    state <= halt ? HALTED : RUN;
                end
                RUN: begin
                    if (fetch_en) begin
                        ir_q       <= bus.rom_inst;
                        ir_pc_q    <= pc;
                        ir_valid_q <= 1'b1;
                        pc         <= next_pc;
                    end else if (halt) begin
                        // Drain the held word, then park; a stalled word keeps us in RUN
                        if (deliver) begin
                            ir_valid_q <= 1'b0;
                        end
                        if (!ir_valid_q || bus.ir_ready) begin
                            state <= HALTED;
                        end
                    end
                end
                HALTED: begin
                    if (deliver) begin
                        ir_valid_q <= 1'b0;
                    end
                    if (!halt) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected deliveries are queued as stimulus
// is applied and popped when the decode handshake completes.
module tb_instruction_fetch;
    import isa_pkg::*;

    typedef struct {
        logic [3:0]  pc;
        logic [15:0] inst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [3:0]  redirect_target;
    logic        halt;
    logic [3:0]  pc;
    logic [15:0] rom [16];

    int passed;
    int total;
    exp_t sb[$];

    instruction_fetch_if bus ();

    assign bus.rom_inst = rom[bus.rom_addr];

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .halt           (halt),
        .pc             (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] p, input logic [15:0] w);
        exp_t e;
        e.pc   = p;
        e.inst = w;
        sb.push_back(e);
    endtask

    // Scoreboard: a delivery is valid&&ready at an edge without rst or redirect
    always @(negedge clk) begin
        if (!rst && !redirect && bus.ir_valid && bus.ir_ready) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                $error("FAIL deliver_unexpected observed ir_pc=%0d ir=%h expected none",
                       bus.ir_pc, bus.ir);
            end else begin
                e = sb.pop_front();
                assert (bus.ir_pc === e.pc && bus.ir === e.inst) passed++;
                else $error("FAIL deliver observed ir_pc=%0d ir=%h expected ir_pc=%0d ir=%h",
                            bus.ir_pc, bus.ir, e.pc, e.inst);
            end
        end
    end

    initial begin
        passed = 0;
        total  = 0;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h1E07;
        rom[1]  = 16'hBE01;
        rom[2]  = 16'hCA00;
        rom[3]  = 16'hFE00;
        rom[4]  = 16'h8100;
        rom[10] = 16'hF200;
        rom[11] = 16'h8A00;
        rom[15] = 16'h0000;

        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_target = 4'd0;
        halt            = 1'b0;
        bus.ir_ready    = 1'b1;

        // Reset state
        step(2);
        check("rst_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(bus.ir), 32'd0);
        check("rst_ir_pc", 32'(bus.ir_pc), 32'd0);

        // Release: bubble, then streaming 0..4 with jmp 4 -> 1
        rst = 1'b0;
        push(4'd0, 16'h1E07); push(4'd1, 16'hBE01); push(4'd2, 16'hCA00);
        push(4'd3, 16'hFE00); push(4'd4, 16'h8100); push(4'd1, 16'hBE01);
        push(4'd2, 16'hCA00);
        step(1);
        check("idle_bubble", 32'(bus.ir_valid), 32'd0);
        step(1);
        check("first_valid", 32'(bus.ir_valid), 32'd1);
        check("first_ir", 32'(bus.ir), 32'h1E07);
        check("first_ir_pc", 32'(bus.ir_pc), 32'd0);
        step(6);
        check("jmp_loop_ir_pc", 32'(bus.ir_pc), 32'd2);

        // Stall 3 cycles with ir_pc=2
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_ir", 32'(bus.ir), 32'hCA00);
            check("stall_ir_pc", 32'(bus.ir_pc), 32'd2);
            check("stall_pc", 32'(pc), 32'd3);
            check("stall_rom_addr", 32'(bus.rom_addr), 32'd3);
            check("stall_valid", 32'(bus.ir_valid), 32'd1);
        end
        bus.ir_ready = 1'b1;
        step(1);
        check("unstall_ir_pc", 32'(bus.ir_pc), 32'd3);
        check("unstall_ir", 32'(bus.ir), 32'hFE00);

        // Redirect to 10 while ir_pc=3 is offered; it is flushed
        redirect        = 1'b1;
        redirect_target = 4'd10;
        step(1);
        check("redir_valid", 32'(bus.ir_valid), 32'd0);
        check("redir_pc", 32'(pc), 32'd10);
        redirect = 1'b0;
        push(4'd10, 16'hF200); push(4'd11, 16'h8A00); push(4'd10, 16'hF200);
        step(1);
        check("redir_first_ir_pc", 32'(bus.ir_pc), 32'd10);
        step(3);
        check("redir_loop_ir_pc", 32'(bus.ir_pc), 32'd11);

        // Redirect during stall with ir_ready=1 in the same cycle
        bus.ir_ready = 1'b0;
        step(1);
        check("stall2_ir_pc", 32'(bus.ir_pc), 32'd11);
        redirect        = 1'b1;
        redirect_target = 4'd15;
        bus.ir_ready    = 1'b1;
        step(1);
        check("redir_stall_valid", 32'(bus.ir_valid), 32'd0);
        check("redir_stall_pc", 32'(pc), 32'd15);
        redirect = 1'b0;
        push(4'd15, 16'h0000); push(4'd0, 16'h1E07); push(4'd1, 16'hBE01);
        step(1);
        check("wrap_ir_pc15", 32'(bus.ir_pc), 32'd15);
        check("wrap_ir15", 32'(bus.ir), 32'h0000);
        step(1);
        check("wrap_ir_pc0", 32'(bus.ir_pc), 32'd0);
        step(1);
        check("pre_halt_ir_pc", 32'(bus.ir_pc), 32'd1);

        // Halt: ir_pc=1 delivered, then parked with pc frozen at 2
        halt = 1'b1;
        step(1);
        check("halt_valid", 32'(bus.ir_valid), 32'd0);
        check("halt_pc", 32'(pc), 32'd2);
        step(2);
        check("halt_hold_pc", 32'(pc), 32'd2);
        check("halt_hold_valid", 32'(bus.ir_valid), 32'd0);
        halt = 1'b0;
        push(4'd2, 16'hCA00);
        step(1);
        check("resume_bubble", 32'(bus.ir_valid), 32'd0);
        step(1);
        check("resume_ir_pc", 32'(bus.ir_pc), 32'd2);
        check("resume_valid", 32'(bus.ir_valid), 32'd1);
        step(1);
        check("resume_next_ir_pc", 32'(bus.ir_pc), 32'd3);

        // Reset mid-stall with a concurrent redirect
        bus.ir_ready = 1'b0;
        step(1);
        check("stall3_ir_pc", 32'(bus.ir_pc), 32'd3);
        rst             = 1'b1;
        redirect        = 1'b1;
        redirect_target = 4'd7;
        step(1);
        check("rst_mid_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_mid_pc", 32'(pc), 32'd0);
        check("rst_mid_ir", 32'(bus.ir), 32'd0);
        rst      = 1'b0;
        redirect = 1'b0;
        step(1);
        check("post_rst_valid", 32'(bus.ir_valid), 32'd0);
        check("post_rst_pc", 32'(pc), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
